// File: rtl/game_pkg.sv
// Shared maze types: facing directions, tile kinds, actor states and direction helpers.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    TILE_WALL        = 2'b00,
    TILE_EMPTY       = 2'b01,
    TILE_PELLET      = 2'b10,
    TILE_GHOST_HOUSE = 2'b11
  } tile_t;

  typedef enum logic [1:0] {
    ST_START  = 2'b00,
    ST_NORMAL = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_DEATH  = 2'b11
  } actor_state_t;

  // Codes are chosen so that bitwise inversion is the opposite heading.
  function automatic dir_t reverse_dir(dir_t d);
    return dir_t'(~d);
  endfunction

  function automatic dir_t rotate_cw(dir_t d);
    case (d)
      DIR_RIGHT: return DIR_DOWN;
      DIR_DOWN:  return DIR_LEFT;
      DIR_LEFT:  return DIR_UP;
      default:   return DIR_RIGHT;
    endcase
  endfunction

  function automatic dir_t rotate_ccw(dir_t d);
    case (d)
      DIR_RIGHT: return DIR_UP;
      DIR_UP:    return DIR_LEFT;
      DIR_LEFT:  return DIR_DOWN;
      default:   return DIR_RIGHT;
    endcase
  endfunction

  function automatic tile_t tile_in_dir(logic [7:0] info, dir_t d);
    case (d)
      DIR_RIGHT: return tile_t'(info[1:0]);
      DIR_UP:    return tile_t'(info[3:2]);
      DIR_DOWN:  return tile_t'(info[5:4]);
      default:   return tile_t'(info[7:6]);
    endcase
  endfunction

endpackage

// File: rtl/maze_actor_btn_edge.sv
// Rising-edge detector for a frame-rate button: fires for one frame when the
// two-stage history reads old=0, new=1.
module btn_edge (
  input  logic clk60,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic [1:0] sr_q, sr_d;

  always_comb begin
    sr_d = {sr_q[0], btn};
  end

  always_ff @(posedge clk60) begin
    if (rst) sr_q <= 2'b00;
    else     sr_q <= sr_d;
  end

  assign rise = (sr_q == 2'b01);

endmodule

// File: rtl/maze_actor_mover.sv
// Per-frame movement engine for one maze actor: speed accumulator, buffered
// relative turns, tunnel wrap and a timed death sequence.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_START  | parked at spawn point, waiting for start
// ST_NORMAL | moving; turns applied, accumulator running
// ST_PAUSE  | everything frozen, button edges still queued
// ST_DEATH  | position frozen, death animation counter running
module maze_actor_mover
  import game_pkg::*;
#(
  parameter int TILE_SHIFT   = 3,
  parameter int X_W          = 9,
  parameter int Y_W          = 9,
  parameter int Y_TILE_OFS   = 3,
  parameter int START_X      = 119,
  parameter int START_Y      = 227,
  parameter int MAZE_COLS    = 28,
  parameter int SPEED_W      = 7,
  parameter int DEATH_FRAMES = 90
) (
  input  logic             clk60,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             kill,
  input  logic             turn_left,
  input  logic             turn_right,
  input  logic             uturn,
  input  logic [SPEED_W:0] speed,
  input  logic [7:0]       tile_info,
  output logic [5:0]       tile_x,
  output logic [5:0]       tile_y,
  output logic [X_W-1:0]   xloc,
  output logic [Y_W-1:0]   yloc,
  output logic [1:0]       dir,
  output logic [1:0]       anim_cycle,
  output logic             step,
  output logic             death_done
);

  localparam int CNT_W = $clog2(DEATH_FRAMES);
  localparam logic [X_W-1:0]   X_MAX_V   = X_W'(MAZE_COLS * (1 << TILE_SHIFT) - 1);
  localparam logic [X_W-1:0]   START_X_V = X_W'(START_X);
  localparam logic [Y_W-1:0]   START_Y_V = Y_W'(START_Y);
  localparam logic [SPEED_W:0] SPEED_ONE = {1'b1, {SPEED_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEATH_FRAMES - 1);

  actor_state_t     state_q, state_d;
  logic [X_W-1:0]   xloc_q, xloc_d;
  logic [Y_W-1:0]   yloc_q, yloc_d;
  dir_t             dir_q, dir_d;
  dir_t             queue_q, queue_d;
  logic [1:0]       anim_q, anim_d;
  logic             half_q, half_d;
  logic [SPEED_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             done_q, done_d;

  logic             left_rise, right_rise, uturn_rise;
  dir_t             q_eff, dir_n;
  tile_t            t_queue, t_ahead;
  logic             centre, turn_now, blocked, moved;
  logic [SPEED_W:0] spd, sum;

  btn_edge u_edge_left  (.clk60(clk60), .rst(rst), .btn(turn_left),  .rise(left_rise));
  btn_edge u_edge_right (.clk60(clk60), .rst(rst), .btn(turn_right), .rise(right_rise));
  btn_edge u_edge_uturn (.clk60(clk60), .rst(rst), .btn(uturn),      .rise(uturn_rise));

  always_comb begin
    state_d  = state_q;
    xloc_d   = xloc_q;
    yloc_d   = yloc_q;
    dir_d    = dir_q;
    queue_d  = DIR_RIGHT;
    anim_d   = anim_q;
    half_d   = half_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    turn_now = 1'b0;
    moved    = 1'b0;

    // A fresh button edge replaces whatever turn was pending.
    q_eff = queue_q;
    if (left_rise)       q_eff = rotate_ccw(dir_q);
    else if (right_rise) q_eff = rotate_cw(dir_q);
    else if (uturn_rise) q_eff = reverse_dir(dir_q);

    centre  = (xloc_q[2:0] == 3'd3) && (yloc_q[2:0] == 3'd3);
    t_queue = tile_in_dir(tile_info, q_eff);

    dir_n = dir_q;
    if (q_eff == reverse_dir(dir_q)) begin
      dir_n = q_eff;
    end else if (q_eff != dir_q && centre &&
                 t_queue != TILE_WALL && t_queue != TILE_GHOST_HOUSE) begin
      dir_n    = q_eff;
      turn_now = 1'b1;
    end
    t_ahead = tile_in_dir(tile_info, dir_n);
    blocked = centre && (t_ahead == TILE_WALL);

    spd = (speed > SPEED_ONE) ? SPEED_ONE : speed;
    sum = {1'b0, acc_q} + spd;

    case (state_q)
      ST_START: begin
        xloc_d = START_X_V;
        yloc_d = START_Y_V;
        dir_d  = DIR_RIGHT;
        anim_d = 2'b01;
        half_d = 1'b0;
        acc_d  = '0;
        cnt_d  = '0;
        if (start) state_d = ST_NORMAL;
      end

      ST_NORMAL: begin
        queue_d = q_eff;
        dir_d   = dir_n;
        if (turn_now || blocked) begin
          acc_d = '0;
        end else begin
          acc_d = sum[SPEED_W-1:0];
          moved = sum[SPEED_W];
        end
        if (moved) begin
          case (dir_n)
            DIR_RIGHT: xloc_d = (xloc_q == X_MAX_V) ? '0 : xloc_q + X_W'(1);
            DIR_LEFT:  xloc_d = (xloc_q == '0) ? X_MAX_V : xloc_q - X_W'(1);
            DIR_UP:    yloc_d = yloc_q - Y_W'(1);
            default:   yloc_d = yloc_q + Y_W'(1);
          endcase
          step_d = 1'b1;
          half_d = ~half_q;
          if (half_q) anim_d = anim_q + 2'd1;
        end else if (anim_q == 2'b00) begin
          anim_d = 2'b01;
        end
        if (kill)       state_d = ST_DEATH;
        else if (pause) state_d = ST_PAUSE;
      end

      ST_PAUSE: begin
        queue_d = q_eff;
        if (!pause) state_d = ST_NORMAL;
      end

      default: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_START;
          cnt_d   = '0;
          done_d  = 1'b1;
          xloc_d  = START_X_V;
          yloc_d  = START_Y_V;
          dir_d   = DIR_RIGHT;
          anim_d  = 2'b01;
          half_d  = 1'b0;
          acc_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          anim_d = cnt_d[CNT_W-1 -: 2];
        end
      end
    endcase
  end

  always_ff @(posedge clk60) begin
    if (rst) begin
      state_q <= ST_START;
      xloc_q  <= START_X_V;
      yloc_q  <= START_Y_V;
      dir_q   <= DIR_RIGHT;
      queue_q <= DIR_RIGHT;
      anim_q  <= 2'b01;
      half_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xloc_q  <= xloc_d;
      yloc_q  <= yloc_d;
      dir_q   <= dir_d;
      queue_q <= queue_d;
      anim_q  <= anim_d;
      half_q  <= half_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign tile_x     = 6'(xloc_q >> TILE_SHIFT);
  assign tile_y     = 6'((yloc_q >> TILE_SHIFT) - Y_W'(Y_TILE_OFS));
  assign xloc       = xloc_q;
  assign yloc       = yloc_q;
  assign dir        = dir_q;
  assign anim_cycle = anim_q;
  assign step       = step_q;
  assign death_done = done_q;

endmodule

// File: tb/tb_maze_actor_mover.sv
// Frame-by-frame bench for maze_actor_mover: a vector table for the straight run,
// wall stop, turn and death timing, then hand-built wrap and pause sequences.
module tb_maze_actor_mover;

  logic       clk60 = 1'b0;
  logic       rst, start, pause, kill, turn_left, turn_right, uturn;
  logic [7:0] speed, tile_info;
  logic [5:0] tile_x, tile_y;
  logic [8:0] xloc, yloc;
  logic [1:0] dir, anim_cycle;
  logic       step, death_done;

  always #5 clk60 = ~clk60;

  maze_actor_mover dut (
    .clk60(clk60), .rst(rst), .start(start), .pause(pause), .kill(kill),
    .turn_left(turn_left), .turn_right(turn_right), .uturn(uturn),
    .speed(speed), .tile_info(tile_info),
    .tile_x(tile_x), .tile_y(tile_y), .xloc(xloc), .yloc(yloc),
    .dir(dir), .anim_cycle(anim_cycle), .step(step), .death_done(death_done)
  );

  localparam int F_R = 1, F_S = 2, F_P = 4, F_K = 8, F_TL = 16, F_TR = 32, F_UT = 64;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] d;
    logic       st;
    logic       dn;
  } exp_t;

  typedef struct {
    int   flags;
    logic [7:0] spd;
    logic [7:0] tile;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mkv(int flags, int spd, int tile, int x, int y, int d, logic st, logic dn);
    vec_t v;
    v.flags = flags;
    v.spd   = 8'(spd);
    v.tile  = 8'(tile);
    v.e.x   = 9'(x);
    v.e.y   = 9'(y);
    v.e.d   = 2'(d);
    v.e.st  = st;
    v.e.dn  = dn;
    return v;
  endfunction

  task automatic check_val(string name, int got, int expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic apply(string name, vec_t v);
    exp_t g, e;
    rst        = (v.flags & F_R)  != 0;
    start      = (v.flags & F_S)  != 0;
    pause      = (v.flags & F_P)  != 0;
    kill       = (v.flags & F_K)  != 0;
    turn_left  = (v.flags & F_TL) != 0;
    turn_right = (v.flags & F_TR) != 0;
    uturn      = (v.flags & F_UT) != 0;
    speed      = v.spd;
    tile_info  = v.tile;
    sb.push_back(v.e);
    @(posedge clk60);
    #1;
    g = '{x: xloc, y: yloc, d: dir, st: step, dn: death_done};
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got x=%0d y=%0d dir=%0d step=%0d done=%0d, expected x=%0d y=%0d dir=%0d step=%0d done=%0d",
                 name, g.x, g.y, g.d, g.st, g.dn, e.x, e.y, e.d, e.st, e.dn);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; kill = 1'b0;
    turn_left = 1'b0; turn_right = 1'b0; uturn = 1'b0;
    speed = 8'd0; tile_info = 8'h55;
    repeat (3) @(posedge clk60);
    #1;
    check_val("rst_xloc", xloc, 119);
    check_val("rst_yloc", yloc, 227);
    check_val("rst_dir", dir, 0);
    check_val("rst_anim", anim_cycle, 1);
    check_val("rst_step", step, 0);
    check_val("rst_done", death_done, 0);
    check_val("rst_tile_x", tile_x, 14);
    check_val("rst_tile_y", tile_y, 25);

    // straight run, half speed, stop, wall, left turn, kill+pause, death timing
    tbl.push_back(mkv(F_S, 128, 'h55, 119, 227, 0, 0, 0));
    tbl.push_back(mkv(0,   128, 'h55, 120, 227, 0, 1, 0));
    tbl.push_back(mkv(0,   128, 'h55, 121, 227, 0, 1, 0));
    tbl.push_back(mkv(0,    64, 'h55, 121, 227, 0, 0, 0));
    tbl.push_back(mkv(0,    64, 'h55, 122, 227, 0, 1, 0));
    tbl.push_back(mkv(0,    64, 'h55, 122, 227, 0, 0, 0));
    tbl.push_back(mkv(0,    64, 'h55, 123, 227, 0, 1, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mkv(0, 0, 'h55, 123, 227, 0, 0, 0));
    for (int i = 0; i < 3; i++)  tbl.push_back(mkv(0, 128, 'h54, 123, 227, 0, 0, 0));
    tbl.push_back(mkv(F_TL, 128, 'h54, 123, 227, 0, 0, 0));
    tbl.push_back(mkv(0,    128, 'h54, 123, 227, 1, 0, 0));
    tbl.push_back(mkv(0,    128, 'h55, 123, 226, 1, 1, 0));
    tbl.push_back(mkv(0,    128, 'h55, 123, 225, 1, 1, 0));
    tbl.push_back(mkv(F_P | F_K, 128, 'h55, 123, 224, 1, 1, 0));
    for (int i = 0; i < 89; i++) tbl.push_back(mkv(0, 128, 'h55, 123, 224, 1, 0, 0));
    tbl.push_back(mkv(0, 128, 'h55, 119, 227, 0, 0, 1));
    tbl.push_back(mkv(0, 128, 'h55, 119, 227, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl[%0d]", i), tbl[i]);
    check_val("anim_after_death", anim_cycle, 1);

    // tunnel wrap both ways
    apply("wrap_start",  mkv(F_S,  128, 'h55, 119, 227, 0, 0, 0));
    apply("wrap_press",  mkv(F_UT, 128, 'h55, 120, 227, 0, 1, 0));
    apply("wrap_rev",    mkv(0,    128, 'h55, 119, 227, 3, 1, 0));
    for (int xx = 118; xx >= 0; xx--)
      apply($sformatf("run_left_x%0d", xx), mkv(0, 128, 'h55, xx, 227, 3, 1, 0));
    apply("wrap_left",   mkv(F_UT, 128, 'h55, 223, 227, 3, 1, 0));
    check_val("tile_x_wrap", tile_x, 27);
    apply("wrap_right",  mkv(0,    128, 'h55, 0, 227, 0, 1, 0));
    apply("after_wrap",  mkv(0,    128, 'h55, 1, 227, 0, 1, 0));

    // pause freeze, turn queued during pause, illegal turn held pending
    apply("pause_enter", mkv(F_P,        128, 'h55, 2, 227, 0, 1, 0));
    apply("pause_tr",    mkv(F_P | F_TR, 128, 'h55, 2, 227, 0, 0, 0));
    apply("pause_hold1", mkv(F_P,        128, 'h55, 2, 227, 0, 0, 0));
    apply("pause_hold2", mkv(F_P,        128, 'h55, 2, 227, 0, 0, 0));
    apply("pause_hold3", mkv(F_P,        128, 'h55, 2, 227, 0, 0, 0));
    apply("pause_exit",  mkv(0,          128, 'h55, 2, 227, 0, 0, 0));
    apply("to_centre",   mkv(0,          128, 'h55, 3, 227, 0, 1, 0));
    apply("turn_wall",   mkv(0,          128, 'h44, 3, 227, 0, 0, 0));
    apply("turn_ghost",  mkv(0,          128, 'h74, 3, 227, 0, 0, 0));
    apply("turn_down",   mkv(0,          128, 'h55, 3, 227, 2, 0, 0));
    apply("move_down",   mkv(0,          128, 'h55, 3, 228, 2, 1, 0));

    // reset during death, then clamped speed
    apply("kill",        mkv(F_K, 128, 'h55, 3, 229, 2, 1, 0));
    apply("death_1",     mkv(0,   128, 'h55, 3, 229, 2, 0, 0));
    check_val("anim_death", anim_cycle, 0);
    apply("rst_death",   mkv(F_R, 128, 'h55, 119, 227, 0, 0, 0));
    apply("start_hold",  mkv(0,   128, 'h55, 119, 227, 0, 0, 0));
    apply("clamp_start", mkv(F_S, 200, 'h55, 119, 227, 0, 0, 0));
    apply("clamp_1",     mkv(0,   200, 'h55, 120, 227, 0, 1, 0));
    apply("clamp_2",     mkv(0,   200, 'h55, 121, 227, 0, 1, 0));
    apply("clamp_3",     mkv(0,   200, 'h55, 122, 227, 0, 1, 0));

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
